// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port responder: word RAM plus GPIO/timer peripheral page
//
// Serves the single-cycle core's loads and stores. Loads are combinational
// from addr; stores commit on the rising clk edge while memwrite is high.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   memwrite   store strobe
//   addr       byte address (addr[1:0] ignored, whole-word accesses)
//   writedata  store data
//   readdata   load data, combinational from addr and current state
//   gpio_in    asynchronous external inputs (2-flop synchronized)
//   gpio_out   registered output pins
//   irq        level-sensitive timer interrupt (MATCH & IE)
module data_mem_responder #(
    parameter int DEPTH  = 64,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [31:0] ADDR_GPIO_OUT = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_GPIO_IN  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TCOUNT   = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_TCMP     = 32'hFFFF_000C;
    localparam logic [31:0] ADDR_TCTRL    = 32'hFFFF_0010;

    // Word RAM, deliberately without reset.
    logic [31:0] mem_q [DEPTH];

    // Peripheral state.
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       tcount_q, tcount_d;
    logic [31:0]       tcmp_q, tcmp_d;
    logic              match_q, match_d;
    logic              en_q, en_d;
    logic              ie_q, ie_d;

    // Address decode.
    logic [31:0]   word_addr;
    logic          sel_ram;
    logic          sel_gpio_out;
    logic          sel_gpio_in;
    logic          sel_tcount;
    logic          sel_tcmp;
    logic          sel_tctrl;
    logic [AW-1:0] ram_idx;

    logic we_ram;
    logic we_gpio_out;
    logic we_tcount;
    logic we_tcmp;
    logic we_tctrl;
    logic timer_hit;

    // The byte-offset bits carry no meaning for whole-word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    always_comb begin
        word_addr    = {addr[31:2], 2'b00};
        sel_ram      = (addr[31:16] == 16'h0000) &&
                       ({18'b0, addr[15:2]} < 32'(DEPTH));
        sel_gpio_out = (word_addr == ADDR_GPIO_OUT);
        sel_gpio_in  = (word_addr == ADDR_GPIO_IN);
        sel_tcount   = (word_addr == ADDR_TCOUNT);
        sel_tcmp     = (word_addr == ADDR_TCMP);
        sel_tctrl    = (word_addr == ADDR_TCTRL);
        ram_idx      = addr[AW+1:2];
    end

    // Decode is one-hot, so at most one write target per cycle. GPIO_IN and
    // unmapped addresses get no enable, which drops their stores silently.
    assign we_ram      = memwrite && sel_ram;
    assign we_gpio_out = memwrite && sel_gpio_out;
    assign we_tcount   = memwrite && sel_tcount;
    assign we_tcmp     = memwrite && sel_tcmp;
    assign we_tctrl    = memwrite && sel_tctrl;

    // A software load of TCOUNT pre-empts the match check for that edge.
    assign timer_hit = !we_tcount && en_q && (tcount_q == tcmp_q);

    always_comb begin
        gpio_out_d = gpio_out_q;
        tcount_d   = tcount_q;
        tcmp_d     = tcmp_q;
        match_d    = match_q;
        en_d       = en_q;
        ie_d       = ie_q;

        if (we_gpio_out) begin
            gpio_out_d = writedata[GPIO_W-1:0];
        end

        if (we_tcmp) begin
            tcmp_d = writedata;
        end

        if (we_tcount) begin
            tcount_d = writedata;
        end else if (timer_hit) begin
            tcount_d = 32'd0;
        end else if (en_q) begin
            tcount_d = tcount_q + 32'd1;
        end

        if (we_tctrl) begin
            en_d = writedata[1];
            ie_d = writedata[2];
            if (writedata[0]) begin
                match_d = 1'b0;
            end
        end
        // Hardware set is applied last so it wins over a same-edge clear.
        if (timer_hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            tcount_q   <= 32'd0;
            tcmp_q     <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            tcount_q   <= tcount_d;
            tcmp_q     <= tcmp_d;
            match_q    <= match_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
        end
    end

    // RAM keeps its contents through reset, but a store presented while
    // reset is held must not land.
    always_ff @(posedge clk) begin
        if (reset && we_ram) begin
            mem_q[ram_idx] <= writedata;
        end
    end

    // Read mux reflects pre-edge state: no forwarding of a pending store.
    always_comb begin
        readdata = 32'd0;
        if (sel_ram) begin
            readdata = mem_q[ram_idx];
        end else if (sel_gpio_out) begin
            readdata = 32'(gpio_out_q);
        end else if (sel_gpio_in) begin
            readdata = 32'(sync2_q);
        end else if (sel_tcount) begin
            readdata = tcount_q;
        end else if (sel_tcmp) begin
            readdata = tcmp_q;
        end else if (sel_tctrl) begin
            readdata = {29'd0, ie_q, en_q, match_q};
        end
    end

    assign gpio_out = gpio_out_q;
    assign irq      = match_q & ie_q;

endmodule
